alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Pipeline register feeding arithmetic_logic_system: captures decoded operands (A, B, Imm, ALUsrc, ALUop)
//  and destination info from decode, presents them to the ALU for one issue per handshake.
//  Detects read-after-write hazards against in-flight ALU results; stalls or forwards ALUout.
// PARAMETERS
//  DW      16  operand/result width
//  RW      4   register-number width
//  SCW     16  stall-counter width (saturating)
// PORTS
//  clk        in   1    clock; all state updates on rising edge
//  reset      in   1    synchronous, active-high reset
//  flush      in   1    discard held entry (branch redirect)
//  in_valid   in   1    decode presents an instruction
//  in_ready   out  1    stage accepts this cycle
//  in_A/in_B/in_Imm in DW  register-file operands / immediate
//  in_ALUsrc  in   1    1: ALU uses Imm in place of B
//  in_ALUop   in   3    ALU operation code
//  in_rs/in_rt in  RW   source register numbers of in_A/in_B
//  in_rd      in   RW   destination register; in_wb in 1 = writes rd
//  A/B/Imm    out  DW   registered operands to ALU
//  ALUsrc     out  1    registered; ALUop out 3 registered
//  out_valid  out  1    held entry valid; out_ready in 1 = ALU/downstream consumes
//  out_rd     out  RW   registered rd; out_wb out 1 registered wb
//  ALUout     in   DW   combinational ALU result of the held entry
//  stall_cnt  out  SCW  cycles in_valid=1 && in_ready=0, saturating at all-ones
// BEHAVIOUR
//  - Reset (sync): out_valid=0, A=B=Imm=0, ALUsrc=0, ALUop=0, out_rd=0, out_wb=0, stall_cnt=0, prev_wb=0.
//  - issue = out_valid && out_ready; accept = in_valid && in_ready.
//  - in_ready = (!out_valid || out_ready) && !hazard.
//  - Occupancy: accept -> load all fields, out_valid=1 next cycle; issue && !accept -> out_valid=0;
//    neither -> hold every output unchanged (stable while out_valid && !out_ready).
//  - flush: out_valid=0 next cycle, accept suppressed that cycle (in_ready still reported, ignored);
//    flush wins over accept and issue; data registers keep stale values. reset wins over flush.
//  - Hazard: entry "writes r" = wb=1 && rd=r; register 0 never hazards (rs/rt==0 ignored).
//  - prev_rd/prev_wb: rd/wb of the entry issued in the previous cycle (regfile write lands one cycle
//    after issue); cleared to wb=0 on cycle with no issue.
//  - Width: operands pass through unmodified; no arithmetic in this stage except stall_cnt (+1, saturate).
//  - Single entry; no internal buffer beyond the output register; latency in->out = 1 cycle.
// CONFIGURATION
//  ALU_FWD_EN defined:
//   - held entry writes in_rs and issue=1 -> captured A = ALUout (same for in_rt -> B). No stall for it.
//   - prev entry writes in_rs/in_rt (and held does not) -> hazard=1 (result not yet in regfile).
//   - both match: held (newest) wins.
//  ALU_FWD_EN undefined:
//   - hazard=1 whenever held entry (out_valid) or prev entry writes in_rs or in_rt; operands
//     always taken from in_A/in_B.
//  - Imm never forwarded; rt hazard ignored when in_ALUsrc=1 in both modes.
// STRUCTURE
//  - Package alu_stage_pkg: ALUop code localparams (OP_AND=3'b000, rest per ALU table), DW/RW defaults,
//    typedef/struct-equivalent field list for the stage payload.
//  - One sub-module: alu_hazard_detect (combinational; inputs in_rs/in_rt/ALUsrc, held rd/wb/valid,
//    prev rd/wb; outputs hazard, fwd_a, fwd_b). Top holds registers, handshake, stall_cnt.
// TESTING
//  1 reset=1 two cycles with in_valid=1 -> out_valid=0, all outputs 0, stall_cnt=0, then accept next cycle.
//  2 in A=-10,B=-10,ALUop=0,ALUsrc=1,Imm=10, rs=1,rt=2,rd=3,wb=1, out_ready=1 -> next cycle A=16'hFFF6,
//    Imm=10, out_valid=1, out_rd=3.
//  3 out_ready=0 for 4 cycles with in_valid=1 -> outputs held, in_ready=0, stall_cnt=4; release -> issues.
//  4 FWD_EN: held rd=3 wb=1 issuing, ALUout=16'h00F0, new rs=3 -> captured A=16'h00F0, no stall;
//    non-FWD build: same stimulus -> 2 stall cycles, then A=in_A.
//  5 flush with in_valid=1 and held entry -> out_valid=0 next cycle, no new entry captured.
//  6 rs=0 with held rd=0 wb=1 -> no hazard; ALUsrc=1, rt=held rd -> no stall; stall_cnt at FFFF stays FFFF.

Source files
------------

// File: rtl/alu_stage_pkg.sv
// Shared definitions for the ALU operand stage: ALU operation codes,
// default widths and the payload field list carried by the stage.
package alu_stage_pkg;

  localparam int DW_DEF  = 16;
  localparam int RW_DEF  = 4;
  localparam int SCW_DEF = 16;

  // ALU operation codes understood by arithmetic_logic_system
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Payload held by the stage (default-width view of the field list)
  typedef struct packed {
    logic [DW_DEF-1:0] a;
    logic [DW_DEF-1:0] b;
    logic [DW_DEF-1:0] imm;
    logic              alusrc;
    logic [2:0]        aluop;
    logic [RW_DEF-1:0] rd;
    logic              wb;
  } stage_payload_t;

endpackage

// File: rtl/alu_hazard_detect.sv
// Read-after-write hazard detection for the ALU operand stage.
// Build option ALU_FWD_EN: when defined, a result from the entry issuing this
// cycle is forwarded from ALUout instead of stalling; only the entry issued
// last cycle (result not yet in the register file) causes a stall.
module alu_hazard_detect
  import alu_stage_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] in_rs,
  input  logic [RW-1:0] in_rt,
  input  logic          in_ALUsrc,
  input  logic          held_valid,
  input  logic [RW-1:0] held_rd,
  input  logic          held_wb,
  input  logic [RW-1:0] prev_rd,
  input  logic          prev_wb,
  output logic          hazard,
  output logic          fwd_a,
  output logic          fwd_b
);

  logic held_rs, held_rt, prev_rs, prev_rt;

  // Register 0 is hardwired, so it never creates a dependency; rt is
  // irrelevant when the ALU takes the immediate instead of B.
  always_comb begin
    held_rs = held_valid && held_wb && (held_rd == in_rs) && (in_rs != '0);
    held_rt = held_valid && held_wb && (held_rd == in_rt) && (in_rt != '0) && !in_ALUsrc;
    prev_rs = prev_wb && (prev_rd == in_rs) && (in_rs != '0);
    prev_rt = prev_wb && (prev_rd == in_rt) && (in_rt != '0) && !in_ALUsrc;
  end

`ifdef ALU_FWD_EN
  // Held entry is the newest producer: forward it, and only stall on the
  // older in-flight result when the held entry does not supersede it.
  always_comb begin
    fwd_a  = held_rs;
    fwd_b  = held_rt;
    hazard = (prev_rs && !held_rs) || (prev_rt && !held_rt);
  end
`else
  // No bypass path: any in-flight producer of a source register stalls.
  always_comb begin
    fwd_a  = 1'b0;
    fwd_b  = 1'b0;
    hazard = held_rs || held_rt || prev_rs || prev_rt;
  end
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// Single-entry pipeline register between decode and the ALU. Holds operands,
// ALU control and destination info, handles the valid/ready handshake,
// stalls or forwards on RAW hazards and counts decode stall cycles.
// Forwarding is selected by the ALU_FWD_EN macro (see alu_hazard_detect).
module alu_operand_stage
  import alu_stage_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int RW  = RW_DEF,
  parameter int SCW = SCW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_A,
  input  logic [DW-1:0]  in_B,
  input  logic [DW-1:0]  in_Imm,
  input  logic           in_ALUsrc,
  input  logic [2:0]     in_ALUop,
  input  logic [RW-1:0]  in_rs,
  input  logic [RW-1:0]  in_rt,
  input  logic [RW-1:0]  in_rd,
  input  logic           in_wb,
  output logic [DW-1:0]  A,
  output logic [DW-1:0]  B,
  output logic [DW-1:0]  Imm,
  output logic           ALUsrc,
  output logic [2:0]     ALUop,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [RW-1:0]  out_rd,
  output logic           out_wb,
  input  logic [DW-1:0]  ALUout,
  output logic [SCW-1:0] stall_cnt
);

  logic [RW-1:0] prev_rd;
  logic          prev_wb;
  logic          hazard, fwd_a, fwd_b;
  logic          issue, accept;

  alu_hazard_detect #(.RW(RW)) u_hazard (
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_ALUsrc  (in_ALUsrc),
    .held_valid (out_valid),
    .held_rd    (out_rd),
    .held_wb    (out_wb),
    .prev_rd    (prev_rd),
    .prev_wb    (prev_wb),
    .hazard     (hazard),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
  );

  // Handshake: the slot is free when empty or draining this cycle
  always_comb begin
    issue    = out_valid && out_ready;
    in_ready = (!out_valid || out_ready) && !hazard;
    accept   = in_valid && in_ready && !flush;
  end

  // Output register: load on accept, drain on issue, squash on flush
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      Imm       <= '0;
      ALUsrc    <= 1'b0;
      ALUop     <= 3'b000;
      out_rd    <= '0;
      out_wb    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      A         <= fwd_a ? ALUout : in_A;
      B         <= fwd_b ? ALUout : in_B;
      Imm       <= in_Imm;
      ALUsrc    <= in_ALUsrc;
      ALUop     <= in_ALUop;
      out_rd    <= in_rd;
      out_wb    <= in_wb;
    end else if (issue) begin
      out_valid <= 1'b0;
    end
  end

  // Track the entry issued last cycle; its write reaches the regfile a
  // cycle later. A flushed entry is squashed, so it never writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_rd <= '0;
      prev_wb <= 1'b0;
    end else if (issue && !flush) begin
      prev_rd <= out_rd;
      prev_wb <= out_wb;
    end else begin
      prev_wb <= 1'b0;
    end
  end

  // Saturating count of cycles decode was held off
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (in_valid && !in_ready && (stall_cnt != {SCW{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage (default or ALU_FWD_EN build).
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [15:0] in_A, in_B, in_Imm, A, B, Imm, ALUout, stall_cnt;
  logic        in_ALUsrc, ALUsrc, out_valid, out_ready, out_wb, in_wb;
  logic [2:0]  in_ALUop, ALUop;
  logic [3:0]  in_rs, in_rt, in_rd, out_rd;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_stall;
  logic [15:0] exp_a;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_Imm(in_Imm), .in_ALUsrc(in_ALUsrc), .in_ALUop(in_ALUop),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_wb(in_wb),
    .A(A), .B(B), .Imm(Imm), .ALUsrc(ALUsrc), .ALUop(ALUop),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_wb(out_wb),
    .ALUout(ALUout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                       input logic src, input logic [2:0] op, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [3:0] rd, input logic wb);
    in_A = a; in_B = b; in_Imm = imm; in_ALUsrc = src; in_ALUop = op;
    in_rs = rs; in_rt = rt; in_rd = rd; in_wb = wb;
  endtask

  initial begin
    reset = 1; flush = 0; in_valid = 1; out_ready = 1; ALUout = 16'h0;
    drive(16'h1234, 16'h5678, 16'h9ABC, 1'b1, 3'b010, 4'd1, 4'd2, 4'd3, 1'b1);
    // 1: reset held two cycles with in_valid high
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_Imm", Imm, 0);
    chk("rst_ctl", {ALUsrc, ALUop, out_rd, out_wb}, 0);
    chk("rst_stall", stall_cnt, 0);

    // 2: first accept, negative operands pass through unchanged
    reset = 0;
    drive(16'hFFF6, 16'hFFF6, 16'd10, 1'b1, 3'b000, 4'd1, 4'd2, 4'd3, 1'b1);
    #1;
    chk("t2_in_ready", in_ready, 1);
    step();
    chk("t2_valid", out_valid, 1);
    chk("t2_A", A, 16'hFFF6);
    chk("t2_B", B, 16'hFFF6);
    chk("t2_Imm", Imm, 16'd10);
    chk("t2_ctl", {ALUsrc, ALUop}, 4'b1000);
    chk("t2_rd_wb", {out_rd, out_wb}, {4'd3, 1'b1});

    // 3: downstream back-pressure for 4 cycles
    out_ready = 0;
    drive(16'h1111, 16'h2222, 16'h0003, 1'b0, 3'b001, 4'd5, 4'd6, 4'd7, 1'b0);
    #1;
    chk("t3_in_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_hold_A", A, 16'hFFF6);
      chk("t3_hold_valid", out_valid, 1);
    end
    chk("t3_stall", stall_cnt, 4);
    exp_stall = 16'd4;
    out_ready = 1;
    #1;
    chk("t3_release_ready", in_ready, 1);
    step();
    chk("t3_A", A, 16'h1111);
    chk("t3_rd", {out_rd, out_wb}, {4'd7, 1'b0});
    chk("t3_stall_after", stall_cnt, exp_stall);

    // 4: producer of r3 becomes the held entry
    drive(16'hAAAA, 16'hBBBB, 16'h0, 1'b0, 3'b010, 4'd8, 4'd9, 4'd3, 1'b1);
    step();
    chk("t4_prod_A", A, 16'hAAAA);
    // consumer of r3 while the producer issues
    drive(16'h1234, 16'h5678, 16'h0, 1'b0, 3'b110, 4'd3, 4'd4, 4'd5, 1'b1);
    ALUout = 16'h00F0;
`ifdef ALU_FWD_EN
    #1;
    chk("t4f_ready", in_ready, 1);
    step();
    chk("t4f_A", A, 16'h00F0);
    chk("t4f_B", B, 16'h5678);
    chk("t4f_stall", stall_cnt, exp_stall);
    exp_a = 16'h00F0;
`else
    #1;
    chk("t4_ready0", in_ready, 0);
    step();
    exp_stall = exp_stall + 1;
    chk("t4_drain", out_valid, 0);
    chk("t4_ready1", in_ready, 0);
    step();
    exp_stall = exp_stall + 1;
    chk("t4_ready2", in_ready, 1);
    step();
    chk("t4_A", A, 16'h1234);
    chk("t4_valid", out_valid, 1);
    chk("t4_stall", stall_cnt, exp_stall);
    exp_a = 16'h1234;
`endif

    // 5: flush beats a simultaneous accept and issue
    drive(16'hBEEF, 16'hCAFE, 16'h0, 1'b0, 3'b000, 4'd10, 4'd11, 4'd12, 1'b0);
    flush = 1;
    #1;
    chk("t5_ready_reported", in_ready, 1);
    step();
    chk("t5_valid", out_valid, 0);
    chk("t5_A_stale", A, exp_a);
    flush = 0; in_valid = 0;
    step();
    chk("t5_still_empty", out_valid, 0);

    // 6: register 0 never hazards
    in_valid = 1; out_ready = 0;
    drive(16'h0101, 16'h0, 16'h0, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1);
    step();
    chk("t6_held_r0", {out_valid, out_rd, out_wb}, {1'b1, 4'd0, 1'b1});
    out_ready = 1;
    drive(16'h0202, 16'h0, 16'h0, 1'b0, 3'b000, 4'd0, 4'd5, 4'd9, 1'b1);
    #1;
    chk("t6_r0_ready", in_ready, 1);
    step();
    chk("t6_A", A, 16'h0202);
    // rt matches held rd but the immediate is used instead of B
    drive(16'h0303, 16'h0404, 16'h0055, 1'b1, 3'b010, 4'd1, 4'd9, 4'd9, 1'b1);
    #1;
    chk("t6_alusrc_ready", in_ready, 1);
    step();
    chk("t6_alusrc_A", A, 16'h0303);
    chk("t6_alusrc_Imm", Imm, 16'h0055);
    chk("t6_stall", stall_cnt, exp_stall);

    // stall counter saturation
    out_ready = 0;
    drive(16'h0, 16'h0, 16'h0, 1'b0, 3'b000, 4'd0, 4'd0, 4'd1, 1'b0);
    for (int i = 0; i < 32'd65535 - 32'(exp_stall); i++) @(posedge clk);
    #1;
    chk("sat_reach", stall_cnt, 16'hFFFF);
    for (int i = 0; i < 3; i++) step();
    chk("sat_hold", stall_cnt, 16'hFFFF);
    chk("sat_out_held", {out_valid, A}, {1'b1, 16'h0303});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
